// File: rtl/usr_c2h_pktgen_pkg.sv
// Shared definitions for the user-side C2H packet generator: FSM state encodings and
// the tuser bit that marks start-of-packet.
package usr_c2h_pktgen_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StGap,
    StDone
  } state_e;

  localparam int unsigned SopBit = 0;

endpackage

// File: rtl/usr_c2h_keep_gen.sv
// Maps the tail byte count of a packet's last beat to its tkeep mask; a tail of 0
// means the beat is full.
module usr_c2h_keep_gen #(
  parameter int unsigned KEEP_W = 16,
  parameter int unsigned TailW  = $clog2(KEEP_W)
) (
  input  logic [TailW-1:0]  tail_i,
  output logic [KEEP_W-1:0] keep_o
);

  always_comb begin
    keep_o = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      keep_o[i] = (tail_i == '0) || (i < int'(tail_i));
    end
  end

endmodule

// File: rtl/usr_c2h_pktgen.sv
// User C2H AXI-Stream generator: length-programmed packets carrying an incrementing
// 32-bit word pattern. Define USR_C2H_PKTGEN_GAP_EN to add gap_i idle cycles per packet.
module usr_c2h_pktgen
  import usr_c2h_pktgen_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              gen_en_i,
  input  logic [LEN_W-1:0]  pkt_len_i,
  input  logic [31:0]       pkt_num_i,
  input  logic [31:0]       seed_i,
`ifdef USR_C2H_PKTGEN_GAP_EN
  input  logic [7:0]        gap_i,
`endif
  input  logic              s0_axis_c2ha_tready_i,
  output logic [DATA_W-1:0] s0_axis_c2ha_tdata_o,
  output logic [KEEP_W-1:0] s0_axis_c2ha_tkeep_o,
  output logic [KEEP_W-1:0] s0_axis_c2ha_tuser_o,
  output logic              s0_axis_c2ha_tlast_o,
  output logic              s0_axis_c2ha_tvalid_o,
  output logic              gen_busy_o,
  output logic              gen_done_o,
  output logic              gen_err_o,
  output logic [31:0]       pkt_cnt_o
);

  localparam int unsigned Lanes = DATA_W / 32;
  localparam int unsigned TailW = $clog2(KEEP_W);

  state_e             state_q, state_d;
  logic               gen_en_q;
  logic [LEN_W-1:0]   len_q, beats_q, beat_q;
  logic [TailW-1:0]   tail_q;
  logic [31:0]        num_q, word_q, pkt_cnt_q, pkt_cnt_inc;
  logic               err_q;
  logic               start_rise, hs, last_beat, stop_now;
  logic [KEEP_W-1:0]  keep_mask;
`ifdef USR_C2H_PKTGEN_GAP_EN
  logic [7:0]         gap_cnt_q;
  logic               stop_gap;
`endif

  assign start_rise  = gen_en_i & ~gen_en_q;
  assign hs          = (state_q == StSend) & s0_axis_c2ha_tready_i;
  assign last_beat   = (beat_q == beats_q - LEN_W'(1));
  assign pkt_cnt_inc = pkt_cnt_q + 32'd1;
  // Decided at the tlast handshake, so pkt_cnt_q has not yet counted this packet.
  assign stop_now    = ((num_q != '0) && (pkt_cnt_inc == num_q)) || !gen_en_i;
`ifdef USR_C2H_PKTGEN_GAP_EN
  assign stop_gap    = ((num_q != '0) && (pkt_cnt_q == num_q)) || !gen_en_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_rise && (pkt_len_i != '0)) state_d = StLoad;
      StLoad: state_d = StSend;
      StSend: begin
        if (hs && last_beat) begin
`ifdef USR_C2H_PKTGEN_GAP_EN
          if (gap_i != '0) state_d = StGap;
          else if (stop_now) state_d = StDone;
`else
          if (stop_now) state_d = StDone;
`endif
        end
      end
      StGap: begin
`ifdef USR_C2H_PKTGEN_GAP_EN
        if (gap_cnt_q == 8'd1) state_d = stop_gap ? StDone : StSend;
`else
        state_d = StIdle;
`endif
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      gen_en_q  <= 1'b0;
      err_q     <= 1'b0;
      len_q     <= '0;
      num_q     <= '0;
      word_q    <= '0;
      pkt_cnt_q <= '0;
      beats_q   <= '0;
      tail_q    <= '0;
      beat_q    <= '0;
    end else begin
      gen_en_q <= gen_en_i;
      err_q    <= (state_q == StIdle) && start_rise && (pkt_len_i == '0);
      if ((state_q == StIdle) && start_rise && (pkt_len_i != '0)) begin
        len_q     <= pkt_len_i;
        num_q     <= pkt_num_i;
        word_q    <= seed_i;
        pkt_cnt_q <= '0;
        beat_q    <= '0;
      end
      if (state_q == StLoad) begin
        beats_q <= (len_q >> TailW) + LEN_W'(|len_q[TailW-1:0]);
        tail_q  <= len_q[TailW-1:0];
      end
      // The word counter runs on across packets; only a new start reloads it.
      if (hs) begin
        word_q <= word_q + 32'(Lanes);
        if (last_beat) begin
          beat_q    <= '0;
          pkt_cnt_q <= pkt_cnt_inc;
        end else begin
          beat_q <= beat_q + LEN_W'(1);
        end
      end
    end
  end

`ifdef USR_C2H_PKTGEN_GAP_EN
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)               gap_cnt_q <= '0;
    else if (hs && last_beat)   gap_cnt_q <= gap_i;
    else if (state_q == StGap)  gap_cnt_q <= gap_cnt_q - 8'd1;
  end
`endif

  usr_c2h_keep_gen #(
    .KEEP_W (KEEP_W)
  ) u_keep_gen (
    .tail_i (tail_q),
    .keep_o (keep_mask)
  );

  // Stream outputs derive from registered state only, so they hold through stalls.
  always_comb begin
    s0_axis_c2ha_tvalid_o = (state_q == StSend);
    s0_axis_c2ha_tdata_o  = '0;
    s0_axis_c2ha_tkeep_o  = '0;
    s0_axis_c2ha_tuser_o  = '0;
    s0_axis_c2ha_tlast_o  = 1'b0;
    if (state_q == StSend) begin
      for (int k = 0; k < Lanes; k++) begin
        s0_axis_c2ha_tdata_o[32*k +: 32] = word_q + 32'(k);
      end
      s0_axis_c2ha_tkeep_o         = last_beat ? keep_mask : '1;
      s0_axis_c2ha_tuser_o[SopBit] = (beat_q == '0);
      s0_axis_c2ha_tlast_o         = last_beat;
    end
    gen_busy_o = (state_q == StLoad) || (state_q == StSend) || (state_q == StGap);
    gen_done_o = (state_q == StDone);
    gen_err_o  = err_q;
  end

  assign pkt_cnt_o = pkt_cnt_q;

endmodule
